// File: rtl/pipe_stage_skid.sv
// Generic pipeline stage register with valid/ready handshake, stall and synchronous flush.
// SKID=1 adds a second entry so in_ready can come from a flop without losing throughput.
module pipe_stage_skid #(
    parameter int unsigned        DATA_W = 128,
    parameter int unsigned        SKID   = 1,
    parameter logic [DATA_W-1:0]  BUBBLE = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    // State encoding equals the number of held entries.
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } state_e;

    if (SKID != 0) begin : g_skid
        state_e              state_q, state_d;
        logic [DATA_W-1:0]   main_q, main_d;
        logic [DATA_W-1:0]   skid_q, skid_d;
        logic                in_ready_q;
        logic                accept, emit;

        assign accept    = in_valid & in_ready_q;
        assign emit      = (state_q != StEmpty) & out_ready;
        assign in_ready  = in_ready_q;
        assign out_valid = (state_q != StEmpty);
        assign out_data  = main_q;
        assign occupancy = state_q;

        always_comb begin
            state_d = state_q;
            main_d  = main_q;
            skid_d  = skid_q;
            unique case (state_q)
                StEmpty: begin
                    if (accept) begin
                        state_d = StOne;
                        main_d  = in_data;
                    end
                end
                StOne: begin
                    if (accept && emit) begin
                        main_d = in_data;
                    end else if (accept) begin
                        state_d = StTwo;
                        skid_d  = in_data;
                    end else if (emit) begin
                        state_d = StEmpty;
                    end
                end
                StTwo: begin
                    if (emit) begin
                        state_d = StOne;
                        main_d  = skid_q;
                    end
                end
                default: state_d = StEmpty;
            endcase
            // Flush drops everything, including a payload accepted this cycle.
            if (flush) begin
                state_d = StEmpty;
                main_d  = BUBBLE;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q    <= StEmpty;
                main_q     <= BUBBLE;
                skid_q     <= '0;
                in_ready_q <= 1'b1;
            end else begin
                state_q    <= state_d;
                main_q     <= main_d;
                skid_q     <= skid_d;
                in_ready_q <= (state_d != StTwo);
            end
        end
    end else begin : g_single
        logic [DATA_W-1:0] data_q;
        logic              valid_q;
        logic              accept, emit;

        assign in_ready  = ~valid_q | out_ready;
        assign accept    = in_valid & in_ready;
        assign emit      = valid_q & out_ready;
        assign out_valid = valid_q;
        assign out_data  = data_q;
        assign occupancy = {1'b0, valid_q};

        always_ff @(posedge clk) begin
            if (rst || flush) begin
                valid_q <= 1'b0;
                data_q  <= BUBBLE;
            end else if (accept) begin
                valid_q <= 1'b1;
                data_q  <= in_data;
            end else if (emit) begin
                valid_q <= 1'b0;
            end
        end
    end

endmodule
